cic_interp_mc: RTL and testbench

- Multi-channel, time-multiplexed CIC interpolator with a run-time-selectable interpolation ratio.
- Sits between a low-rate multi-channel sample source and a high-rate DAC/mixer path.
- One shared comb and integrator datapath serves NCH channels. Per-channel state is held in register arrays.
- Input uses a valid/ready handshake; output is a channel-tagged sample stream.

---
 rtl/cic_interp_mc_if.sv | 31 +++
 rtl/cic_interp_mc.sv | 203 ++++++++++++++++++++
 tb/tb_cic_interp_mc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cic_interp_mc_if.sv
// Sample-in handshake and channel-tagged sample-out bundle for cic_interp_mc.
interface cic_interp_mc_if #(
  parameter int DW  = 8,
  parameter int DOW = 20,
  parameter int CHW = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  data_in;
  logic                  out_valid;
  logic [CHW-1:0]        out_chan;
  logic signed [DOW-1:0] data_out;

  modport master (
    output in_valid,
    output data_in,
    input  in_ready,
    input  out_valid,
    input  out_chan,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  data_in,
    output in_ready,
    output out_valid,
    output out_chan,
    output data_out
  );
endinterface

// File: rtl/cic_interp_mc.sv
// Time-multiplexed multi-channel CIC interpolator with run-time ratio.
// Optional macro CIC_ROUND_EN: round-half-up + saturate output to OUTW bits (+1 cycle).
module cic_interp_mc #(
  parameter int DW    = 8,
  parameter int M     = 4,
  parameter int G     = 1,
  parameter int R_MAX = 16,
  parameter int NCH   = 2,
  parameter int OUTW  = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic [$clog2(R_MAX+1)-1:0] rate,
  cic_interp_mc_if.slave             bus
);
  localparam int OW  = DW + $clog2(((R_MAX*G)**M)/R_MAX);
  localparam int RW  = $clog2(R_MAX+1);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rdy_en;
  logic                 w_rst;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last_ch;
  logic                 w_last_slot;
  logic [RW-1:0]        w_rate_eff;

  logic [CHW-1:0]       r_ch_cnt;
  logic [RW-1:0]        r_phase;
  logic [RW-1:0]        r_eff;

  logic signed [OW-1:0] r_dly      [NCH][M][G];
  logic signed [OW-1:0] r_comb_buf [NCH];
  logic signed [OW-1:0] r_acc      [NCH][M];
  logic signed [OW-1:0] w_comb     [M+1];
  logic signed [OW-1:0] w_int      [M];
  logic signed [OW-1:0] w_int_in;

  logic                 r_out_valid;
  logic [CHW-1:0]       r_out_chan;
  logic signed [OW-1:0] r_data;

  assign w_rst       = !reset_n || clear;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last_ch   = (r_ch_cnt == CHW'(NCH-1));
  assign w_last_slot = w_last_ch && (r_phase == r_eff - RW'(1));
  assign bus.in_ready = w_in_ready;

  always_comb begin
    w_rate_eff = rate;
    if (rate == '0) begin
      w_rate_eff = RW'(1);
    end else if (rate > RW'(R_MAX)) begin
      w_rate_eff = RW'(R_MAX);
    end
  end

  // r_rdy_en holds in_ready low for the first cycle after reset/clear
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state  <= S_LOAD;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = r_rdy_en;
        if (bus.in_valid && r_rdy_en && w_last_ch) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_slot) begin
          w_state_next = S_LOAD;
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  assign w_comb[0] = {{(OW-DW){bus.data_in[DW-1]}}, bus.data_in};
  assign w_int_in  = (r_phase == '0) ? r_comb_buf[r_ch_cnt] : '0;

  // Comb and integrator chains for the currently selected channel
  for (genvar gi = 0; gi < M; gi++) begin : g_stage
    assign w_comb[gi+1] = w_comb[gi] - r_dly[r_ch_cnt][gi][G-1];
    if (gi == 0) begin : g_first
      assign w_int[gi] = r_acc[r_ch_cnt][gi] + w_int_in;
    end else begin : g_rest
      assign w_int[gi] = r_acc[r_ch_cnt][gi] + w_int[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_ch_cnt    <= '0;
      r_phase     <= '0;
      r_eff       <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_data      <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_comb_buf[c] <= '0;
        for (int k = 0; k < M; k++) begin
          r_acc[c][k] <= '0;
          for (int d = 0; d < G; d++) begin
            r_dly[c][k][d] <= '0;
          end
        end
      end
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        for (int k = 0; k < M; k++) begin
          r_dly[r_ch_cnt][k][0] <= w_comb[k];
          for (int d = 1; d < G; d++) begin
            r_dly[r_ch_cnt][k][d] <= r_dly[r_ch_cnt][k][d-1];
          end
        end
        r_comb_buf[r_ch_cnt] <= w_comb[M];
        if (w_last_ch) begin
          r_ch_cnt <= '0;
          r_phase  <= '0;
          r_eff    <= w_rate_eff;
        end else begin
          r_ch_cnt <= r_ch_cnt + CHW'(1);
        end
      end else if (r_state == S_RUN) begin
        for (int k = 0; k < M; k++) begin
          r_acc[r_ch_cnt][k] <= w_int[k];
        end
        r_data      <= w_int[M-1];
        r_out_valid <= 1'b1;
        r_out_chan  <= r_ch_cnt;
        if (w_last_ch) begin
          r_ch_cnt <= '0;
          r_phase  <= r_phase + RW'(1);
        end else begin
          r_ch_cnt <= r_ch_cnt + CHW'(1);
        end
      end
    end
  end

`ifdef CIC_ROUND_EN
  localparam int SH = OW - OUTW;
  localparam logic signed [OW:0] RND_HALF = (OW+1)'(1) << (SH-1);
  localparam logic signed [OW:0] SAT_MAX  = (OW+1)'((1 << (OUTW-1)) - 1);
  localparam logic signed [OW:0] SAT_MIN  = ~SAT_MAX;

  logic signed [OW:0]     w_rnd_sum;
  logic signed [OW:0]     w_rnd_shr;
  logic                   r_rnd_valid;
  logic [CHW-1:0]         r_rnd_chan;
  logic signed [OUTW-1:0] r_rnd_data;

  // One guard bit keeps the rounding add from wrapping
  assign w_rnd_sum = $signed({r_data[OW-1], r_data}) + RND_HALF;
  assign w_rnd_shr = w_rnd_sum >>> SH;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rnd_valid <= 1'b0;
      r_rnd_chan  <= '0;
      r_rnd_data  <= '0;
    end else begin
      r_rnd_valid <= r_out_valid;
      r_rnd_chan  <= r_out_chan;
      if (w_rnd_shr > SAT_MAX) begin
        r_rnd_data <= SAT_MAX[OUTW-1:0];
      end else if (w_rnd_shr < SAT_MIN) begin
        r_rnd_data <= SAT_MIN[OUTW-1:0];
      end else begin
        r_rnd_data <= w_rnd_shr[OUTW-1:0];
      end
    end
  end

  assign bus.out_valid = r_rnd_valid;
  assign bus.out_chan  = r_rnd_chan;
  assign bus.data_out  = r_rnd_data;
`else
  logic w_unused_outw;
  assign w_unused_outw = ^OUTW;

  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.data_out  = r_data;
`endif

endmodule

// File: tb/tb_cic_interp_mc.sv
// Directed table-driven bench for cic_interp_mc (DW=8, M=2, G=1, R_MAX=8, NCH=2, OW=11).
module tb_cic_interp_mc;
  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [3:0] rate;

  int tests = 0;
  int fails = 0;

  cic_interp_mc_if #(.DW(8), .DOW(11), .CHW(1)) bus ();

  cic_interp_mc #(
    .DW(8), .M(2), .G(1), .R_MAX(8), .NCH(2), .OUTW(12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .rate    (rate),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // One frame: inputs for ch0/ch1, ratio, expected per-phase outputs for each channel
  typedef struct packed {
    logic             clr;
    logic [3:0]       rate;
    logic signed [7:0] x0;
    logic signed [7:0] x1;
    logic [3:0]       nph;
    logic [7:0][15:0] e0;
    logic [7:0][15:0] e1;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  function automatic logic [127:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [7:0] x, input bit rnd, input string tag);
    int guard = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.data_in  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.data_in  = x;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk({tag, " handshake timeout"}, guard, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = 8'($urandom);
  endtask

  task automatic send_frame(input vec_t v, input bit rnd, input string tag);
    if (v.clr) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
    rate = v.rate;
    send(v.x0, rnd, tag);
    send(v.x1, rnd, tag);
  endtask

  task automatic collect(input vec_t v, input string tag);
    int n     = 2 * int'(v.nph);
    int got   = 0;
    int guard = 0;
    int extra = 0;
    int ev;
    bit rdy_bad = 1'b0;
    while (got < n && guard < 80) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) begin
        ev = (got % 2 == 1) ? int'($signed(v.e1[got/2])) : int'($signed(v.e0[got/2]));
        chk($sformatf("%s data[%0d]", tag, got), int'(bus.data_out), ev);
        chk($sformatf("%s chan[%0d]", tag, got), int'(bus.out_chan), got % 2);
        got++;
      end
      if (got < n && bus.in_ready) rdy_bad = 1'b1;
    end
    chk({tag, " output count"}, got, n);
    chk({tag, " in_ready during RUN"}, int'(rdy_bad), 0);
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk({tag, " extra outputs"}, extra, 0);
    $display("[TB] %s rate=%0d x0=%0d x1=%0d outputs=%0d", tag, v.rate, v.x0, v.x1, got);
  endtask

  task automatic run_vec(input vec_t v, input bit rnd, input string tag);
    send_frame(v, rnd, tag);
    collect(v, tag);
  endtask

  // Abort a frame after 3 outputs using reset (use_clear=0) or clear (use_clear=1)
  task automatic abort_mid_run(input bit use_clear, input string tag);
    vec_t v;
    int   k     = 0;
    int   guard = 0;
    int   stray = 0;
    send_frame(tbl[0], 1'b0, tag);
    while (k < 3 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) k++;
    end
    chk({tag, " reached mid-RUN"}, k, 3);
    if (use_clear) clear = 1'b1;
    else reset_n = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid after abort"}, int'(bus.out_valid), 0);
    chk({tag, " data_out after abort"}, int'(bus.data_out), 0);
    chk({tag, " out_chan after abort"}, int'(bus.out_chan), 0);
    chk({tag, " in_ready after abort"}, int'(bus.in_ready), 0);
    clear   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready recovers"}, int'(bus.in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    chk({tag, " no outputs from abandoned frame"}, stray, 0);
    for (int i = 0; i < 3; i++) begin
      v = tbl[i];
      v.clr = 1'b0;
      run_vec(v, 1'b0, $sformatf("%s impulse f%0d", tag, i));
    end
  endtask

  initial begin
    //              clr  rate  x0    x1    nph  e0 / e1 per phase
    tbl[0]  = '{1'b1, 4'd4,  8'sd1,    8'sd0,    4'd4,
                pk8(1, 2, 3, 4, 0, 0, 0, 0), pk8(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 4'd4,  8'sd0,    8'sd0,    4'd4,
                pk8(3, 2, 1, 0, 0, 0, 0, 0), pk8(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 4'd4,  8'sd0,    8'sd0,    4'd4,
                pk8(0, 0, 0, 0, 0, 0, 0, 0), pk8(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 4'd4,  8'sd10,   8'sd10,   4'd4,
                pk8(10, 20, 30, 40, 0, 0, 0, 0), pk8(10, 20, 30, 40, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 4'd4,  8'sd10,   8'sd10,   4'd4,
                pk8(40, 40, 40, 40, 0, 0, 0, 0), pk8(40, 40, 40, 40, 0, 0, 0, 0)};
    tbl[5]  = tbl[4];
    tbl[6]  = '{1'b1, 4'd8,  -8'sd128, -8'sd128, 4'd8,
                pk8(-128, -256, -384, -512, -640, -768, -896, -1024),
                pk8(-128, -256, -384, -512, -640, -768, -896, -1024)};
    tbl[7]  = '{1'b0, 4'd8,  -8'sd128, -8'sd128, 4'd8,
                pk8(-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024),
                pk8(-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024)};
    tbl[8]  = tbl[7];
    tbl[9]  = '{1'b1, 4'd0,  8'sd5,    -8'sd3,   4'd1,
                pk8(5, 0, 0, 0, 0, 0, 0, 0), pk8(-3, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 4'd0,  8'sd7,    8'sd127,  4'd1,
                pk8(7, 0, 0, 0, 0, 0, 0, 0), pk8(127, 0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 4'd0,  -8'sd100, -8'sd128, 4'd1,
                pk8(-100, 0, 0, 0, 0, 0, 0, 0), pk8(-128, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{1'b1, 4'd15, 8'sd0,    8'sd1,    4'd8,
                pk8(0, 0, 0, 0, 0, 0, 0, 0), pk8(1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[13] = '{1'b0, 4'd15, 8'sd0,    8'sd0,    4'd8,
                pk8(0, 0, 0, 0, 0, 0, 0, 0), pk8(7, 6, 5, 4, 3, 2, 1, 0)};
    tbl[14] = '{1'b0, 4'd15, 8'sd0,    8'sd0,    4'd8,
                pk8(0, 0, 0, 0, 0, 0, 0, 0), pk8(0, 0, 0, 0, 0, 0, 0, 0)};

    reset_n      = 1'b0;
    clear        = 1'b0;
    rate         = 4'd4;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset data_out", int'(bus.data_out), 0);
    chk("reset out_chan", int'(bus.out_chan), 0);
    chk("reset in_ready", int'(bus.in_ready), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset release", int'(bus.in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      run_vec(tbl[i], 1'b1, $sformatf("rnd-hs impulse f%0d", i));
    end
    for (int i = 3; i < 6; i++) begin
      run_vec(tbl[i], 1'b1, $sformatf("rnd-hs dc f%0d", i));
    end

    abort_mid_run(1'b0, "reset mid-RUN");
    abort_mid_run(1'b1, "clear mid-RUN");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
